data_path: RTL and testbench
============================

Name: data_path

Overview:
- 32-bit single-bus CPU datapath: register file R0–R15, PC, IR, MAR, MDR, Y, 64-bit Z, a small ALU, and a branch-condition flip-flop (CON FF).
- An external control unit or testbench drives every register-enable, bus-source and ALU-op strobe directly. Memory is external.
- Used to execute fetch and conditional-branch sequences such as brzr/brnz/brpl/brmi.

Parameters:
- none

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous active-low reset; 0 clears all state.
- Mdatain  in  32  data from external memory.
- MD_read  in  1  MDR input select: 1 selects Mdatain, 0 selects bus.
- Read  in  1  memory-read strobe; ORed with MD_read for MDR input select.
- Write  in  1  memory-write strobe; no internal effect.
- PCout, MDRout, Zlowout, Zhighout, Csignout, Rout, BAout  in  1 each  bus-source strobes.
- PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, Rin, CONin  in  1 each  register load enables.
- Gra, Grb  in  1 each  select register field ra or rb.
- IncPC, ADD  in  1 each  ALU operation selects.
- CONFF  out  1  branch condition flip-flop.
- BusMuxOut  out  32  current bus value.
- MAR_q  out  32  MAR contents (address to external memory).

Behaviour:
- Reset (clear=0, async): R0–R15, PC, IR, MAR, MDR, Y, Z[63:0] and CONFF all go to 0 immediately.
- Register loads:
  - With clear=1, a register loads on posedge clock while its enable is high; otherwise it holds.
  - PC, IR, MAR and Y load from BusMuxOut.
  - MDR loads from Mdatain if (MD_read|Read), else from the bus.
- IR fields:
  - ra=IR[26:23], rb=IR[22:19], C2=IR[20:19].
  - C = sign-extended IR[18:0], i.e. {13{IR[18]}}, IR[18:0].
- Register select:
  - Selected index = ra if Gra, else rb if Grb, else none.
  - Rin with a selected index loads R[index] from the bus.
  - Rin with no selection does nothing.
- Bus source, combinational priority when several strobes are high: PCout > MDRout > Zlowout (Z[31:0]) > Zhighout (Z[63:32]) > Csignout (C) > Rout/BAout (R[index]).
  - Under BAout, R0 reads as 0.
  - Rout or BAout with no Gra/Grb gives 0.
  - No strobe active gives bus = 0.
- ALU, combinational; A=Y, B=BusMuxOut:
  - IncPC: result = B+1.
  - ADD: result = A+B, mod 2^32.
  - IncPC has priority over ADD.
  - Neither: result = 0.
  - Result goes to Z[31:0]; Z[63:32] always receives 0.
  - Zlowin loads Z[31:0]; Zhighin loads Z[63:32].
- CON FF:
  - On posedge with CONin=1, CONFF loads the condition evaluated on BusMuxOut per C2.
  - C2=00: bus==0. C2=01: bus!=0. C2=10: bus[31]==0 (positive). C2=11: bus[31]==1 (negative).
  - Otherwise CONFF holds.
- Conditional branch: the controller gates PCin with CONFF. The datapath itself treats PCin unconditionally.
- Simultaneous load and read of the same register in one cycle: the bus sees the old value; the new value is visible after the edge.
- Reset asserted mid-sequence clears state at once; loads resume on the first rising edge after clear returns high.

Test Plan:
- Reset: pulse clear=0 with random strobes active -> all registers, Z and CONFF read 0; BusMuxOut=0 with no strobes.
- Fetch: PC=0; cycle PCout+MARin+IncPC+Zlowin -> MAR=0, Z=1. Then Zlowout+PCin+Read+MDRin with Mdatain=0x98800000 -> PC=1, MDR=0x98800000. Then MDRout+IRin -> IR=0x98800000.
- brzr taken: IR=0x98800000 (ra=1, C2=00, C=0), R1=0; Gra+Rout+CONin -> CONFF=1. PCout+Yin -> Y=1. Csignout+ADD+Zlowin -> Z=1. Zlowout with PCin=CONFF -> PC=1.
- brzr not taken: load R1=5 via MDRout+Gra+Rin; repeat the sequence -> CONFF=0, PC unchanged.
- Condition coverage: C2=01/10/11 with bus 0, 0x00000007 and 0x80000000 -> CONFF follows the nonzero/positive/negative rule for each.
- Sign extension and ALU: IR[18:0]=0x7FFFF (C=-1), Y=5, Csignout+ADD+Zlowin -> Z[31:0]=4, Z[63:32]=0. BAout with ra=0 -> bus=0 even if R0=0x1234.

Source files
------------

// File: rtl/data_path_if.sv
// Control and data bundle for the single-bus datapath.
// The master side (control unit or bench) drives every strobe and memory data;
// the slave side (the datapath) returns the bus, the MAR address and CON FF.
interface data_path_if;
    logic [31:0] Mdatain;
    logic        MD_read;
    logic        Read;
    logic        Write;

    logic        PCout;
    logic        MDRout;
    logic        Zlowout;
    logic        Zhighout;
    logic        Csignout;
    logic        Rout;
    logic        BAout;

    logic        PCin;
    logic        IRin;
    logic        MARin;
    logic        MDRin;
    logic        Yin;
    logic        Zlowin;
    logic        Zhighin;
    logic        Rin;
    logic        CONin;

    logic        Gra;
    logic        Grb;
    logic        IncPC;
    logic        ADD;

    logic        CONFF;
    logic [31:0] BusMuxOut;
    logic [31:0] MAR_q;

    modport master (
        output Mdatain, MD_read, Read, Write,
        output PCout, MDRout, Zlowout, Zhighout, Csignout, Rout, BAout,
        output PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, Rin, CONin,
        output Gra, Grb, IncPC, ADD,
        input  CONFF, BusMuxOut, MAR_q
    );

    modport slave (
        input  Mdatain, MD_read, Read, Write,
        input  PCout, MDRout, Zlowout, Zhighout, Csignout, Rout, BAout,
        input  PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, Rin, CONin,
        input  Gra, Grb, IncPC, ADD,
        output CONFF, BusMuxOut, MAR_q
    );
endinterface

// File: rtl/data_path.sv
// 32-bit single-bus CPU datapath: R0-R15, PC, IR, MAR, MDR, Y, 64-bit Z,
// a small ALU and the branch-condition flip-flop. All sequencing comes from
// the external controller through the interface strobes.
module data_path (
    input  logic       clock,
    input  logic       clear,
    data_path_if.slave dp
);

    logic [31:0] r_regFile [16];
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mar;
    logic [31:0] r_mdr;
    logic [31:0] r_y;
    logic [63:0] r_z;
    logic        r_conff;

    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [1:0]  w_c2;
    logic [31:0] w_csign;
    logic        w_regSelValid;
    logic [3:0]  w_regIdx;
    logic [31:0] w_regValue;
    logic [31:0] w_bus;
    logic [31:0] w_aluResult;
    logic [31:0] w_mdrIn;
    logic        w_condition;
    logic [5:0]  w_unused;

    // Instruction fields; C is the sign-extended 19-bit immediate
    assign w_ra    = r_ir[26:23];
    assign w_rb    = r_ir[22:19];
    assign w_c2    = r_ir[20:19];
    assign w_csign = {{13{r_ir[18]}}, r_ir[18:0]};

    // The memory-write strobe and the opcode bits have no effect inside the datapath
    assign w_unused = {dp.Write, r_ir[31:27]};

    // Register-file index: ra takes precedence over rb, no selection reads as 0
    always_comb begin
        w_regSelValid = dp.Gra | dp.Grb;
        w_regIdx      = 4'd0;
        if (dp.Gra) begin
            w_regIdx = w_ra;
        end else if (dp.Grb) begin
            w_regIdx = w_rb;
        end
        w_regValue = w_regSelValid ? r_regFile[w_regIdx] : 32'd0;
    end

    // Bus source priority encoder; BAout forces R0 to read as zero
    always_comb begin
        w_bus = 32'd0;
        if (dp.PCout) begin
            w_bus = r_pc;
        end else if (dp.MDRout) begin
            w_bus = r_mdr;
        end else if (dp.Zlowout) begin
            w_bus = r_z[31:0];
        end else if (dp.Zhighout) begin
            w_bus = r_z[63:32];
        end else if (dp.Csignout) begin
            w_bus = w_csign;
        end else if (dp.Rout) begin
            w_bus = w_regValue;
        end else if (dp.BAout) begin
            w_bus = (w_regIdx == 4'd0) ? 32'd0 : w_regValue;
        end
    end

    // ALU with A from Y and B from the bus; IncPC wins over ADD
    always_comb begin
        w_aluResult = 32'd0;
        if (dp.IncPC) begin
            w_aluResult = w_bus + 32'd1;
        end else if (dp.ADD) begin
            w_aluResult = r_y + w_bus;
        end
    end

    // MDR takes memory data on a read, otherwise the bus
    assign w_mdrIn = (dp.MD_read | dp.Read) ? dp.Mdatain : w_bus;

    // Branch condition evaluated on the bus value according to C2
    always_comb begin
        w_condition = 1'b0;
        case (w_c2)
            2'b00:   w_condition = (w_bus == 32'd0);
            2'b01:   w_condition = (w_bus != 32'd0);
            2'b10:   w_condition = ~w_bus[31];
            default: w_condition = w_bus[31];
        endcase
    end

    // General-purpose register file, written from the bus under Rin
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) begin
                r_regFile[i] <= 32'd0;
            end
        end else if (dp.Rin && w_regSelValid) begin
            r_regFile[w_regIdx] <= w_bus;
        end
    end

    // Dedicated registers PC, IR, MAR, MDR and Y
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_pc  <= 32'd0;
            r_ir  <= 32'd0;
            r_mar <= 32'd0;
            r_mdr <= 32'd0;
            r_y   <= 32'd0;
        end else begin
            if (dp.PCin)  r_pc  <= w_bus;
            if (dp.IRin)  r_ir  <= w_bus;
            if (dp.MARin) r_mar <= w_bus;
            if (dp.MDRin) r_mdr <= w_mdrIn;
            if (dp.Yin)   r_y   <= w_bus;
        end
    end

    // Z halves load independently; the ALU upper word is always zero
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_z <= 64'd0;
        end else begin
            if (dp.Zlowin)  r_z[31:0]  <= w_aluResult;
            if (dp.Zhighin) r_z[63:32] <= 32'd0;
        end
    end

    // CON FF captures the branch condition under CONin
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_conff <= 1'b0;
        end else if (dp.CONin) begin
            r_conff <= w_condition;
        end
    end

    assign dp.BusMuxOut = w_bus;
    assign dp.MAR_q     = r_mar;
    assign dp.CONFF     = r_conff;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: expected values are pushed to a
// scoreboard queue when stimulus is applied and popped when the DUT is sampled.
module tb_data_path;

    logic clock;
    logic clear;

    data_path_if dp ();

    data_path u_dut (
        .clock (clock),
        .clear (clear),
        .dp    (dp)
    );

    // Free-running 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int          nVec;
    int          nErr;
    logic [31:0] expQ [$];
    logic [31:0] expVal;

    // Move to 1 ns after the next rising edge so samples sit away from it
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clearStrobes;
        dp.Mdatain  = 32'd0;
        dp.MD_read  = 1'b0;
        dp.Read     = 1'b0;
        dp.Write    = 1'b0;
        dp.PCout    = 1'b0;
        dp.MDRout   = 1'b0;
        dp.Zlowout  = 1'b0;
        dp.Zhighout = 1'b0;
        dp.Csignout = 1'b0;
        dp.Rout     = 1'b0;
        dp.BAout    = 1'b0;
        dp.PCin     = 1'b0;
        dp.IRin     = 1'b0;
        dp.MARin    = 1'b0;
        dp.MDRin    = 1'b0;
        dp.Yin      = 1'b0;
        dp.Zlowin   = 1'b0;
        dp.Zhighin  = 1'b0;
        dp.Rin      = 1'b0;
        dp.CONin    = 1'b0;
        dp.Gra      = 1'b0;
        dp.Grb      = 1'b0;
        dp.IncPC    = 1'b0;
        dp.ADD      = 1'b0;
    endtask

    // MDR <- memory data
    task automatic loadMdr(input logic [31:0] val);
        clearStrobes();
        dp.Mdatain = val;
        dp.Read    = 1'b1;
        dp.MDRin   = 1'b1;
        tick();
        clearStrobes();
    endtask

    // IR <- value routed through MDR
    task automatic loadIr(input logic [31:0] val);
        loadMdr(val);
        dp.MDRout = 1'b1;
        dp.IRin   = 1'b1;
        tick();
        clearStrobes();
    endtask

    // R[ra] <- value routed through MDR
    task automatic loadRa(input logic [31:0] val);
        loadMdr(val);
        dp.MDRout = 1'b1;
        dp.Gra    = 1'b1;
        dp.Rin    = 1'b1;
        tick();
        clearStrobes();
    endtask

    function automatic logic condModel(input logic [1:0] c2, input logic [31:0] v);
        case (c2)
            2'b00:   return v == 32'd0;
            2'b01:   return v != 32'd0;
            2'b10:   return v[31] == 1'b0;
            default: return v[31] == 1'b1;
        endcase
    endfunction

    task automatic test_reset;
        logic [22:0] rnd;
        // Build up non-zero state first
        loadMdr(32'hDEADBEEF);
        dp.MDRout = 1'b1; dp.PCin = 1'b1; dp.MARin = 1'b1; dp.Yin = 1'b1;
        dp.IRin = 1'b1; dp.IncPC = 1'b1; dp.Zlowin = 1'b1;
        tick();
        // Assert clear between edges with random strobes active
        rnd = 23'($urandom);
        {dp.PCout, dp.MDRout, dp.Zlowout, dp.Zhighout, dp.Csignout, dp.Rout, dp.BAout,
         dp.PCin, dp.IRin, dp.MARin, dp.MDRin, dp.Yin, dp.Zlowin, dp.Zhighin, dp.Rin,
         dp.CONin, dp.Gra, dp.Grb, dp.IncPC, dp.ADD, dp.Read, dp.MD_read, dp.Write} = rnd;
        dp.Mdatain = 32'h5A5A5A5A;
        @(negedge clock);
        clear = 1'b0;
        expQ.push_back(32'd0);
        expQ.push_back(32'd0);
        #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.MAR_q !== expVal) begin nErr++; $display("[TB] FAIL reset_mar got=%h exp=%h", dp.MAR_q, expVal); end
        expVal = expQ.pop_front(); nVec++;
        if ({31'd0, dp.CONFF} !== expVal) begin nErr++; $display("[TB] FAIL reset_conff got=%b exp=%h", dp.CONFF, expVal); end
        // Edges while clear is low must not load anything
        tick();
        clearStrobes();
        expQ.push_back(32'd0);
        #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL reset_idle_bus got=%h exp=%h", dp.BusMuxOut, expVal); end
        dp.PCout = 1'b1; expQ.push_back(32'd0); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL reset_pc got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes(); dp.MDRout = 1'b1; expQ.push_back(32'd0); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL reset_mdr got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes(); dp.Zlowout = 1'b1; expQ.push_back(32'd0); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL reset_zlow got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes(); dp.Csignout = 1'b1; expQ.push_back(32'd0); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL reset_ir got=%h exp=%h", dp.BusMuxOut, expVal); end
        // Release and confirm Y cleared: Z <- Y + 0
        @(negedge clock);
        clear = 1'b1;
        clearStrobes();
        dp.ADD = 1'b1; dp.Zlowin = 1'b1;
        tick();
        clearStrobes(); dp.Zlowout = 1'b1; expQ.push_back(32'd0); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL reset_y got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes();
    endtask

    task automatic test_fetch;
        clearStrobes();
        dp.PCout = 1'b1; dp.MARin = 1'b1; dp.IncPC = 1'b1; dp.Zlowin = 1'b1;
        expQ.push_back(32'd0);
        expQ.push_back(32'd1);
        tick();
        clearStrobes();
        expVal = expQ.pop_front(); nVec++;
        if (dp.MAR_q !== expVal) begin nErr++; $display("[TB] FAIL fetch_mar got=%h exp=%h", dp.MAR_q, expVal); end
        dp.Zlowout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL fetch_z got=%h exp=%h", dp.BusMuxOut, expVal); end
        dp.PCin = 1'b1; dp.Read = 1'b1; dp.MDRin = 1'b1; dp.Mdatain = 32'h98800000;
        expQ.push_back(32'd1);
        expQ.push_back(32'h98800000);
        tick();
        clearStrobes(); dp.PCout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL fetch_pc got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes(); dp.MDRout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL fetch_mdr got=%h exp=%h", dp.BusMuxOut, expVal); end
        dp.IRin = 1'b1;
        tick();
        clearStrobes();
    endtask

    task automatic branchSequence(input logic expCon, input string tag);
        clearStrobes();
        dp.Gra = 1'b1; dp.Rout = 1'b1; dp.CONin = 1'b1;
        expQ.push_back({31'd0, expCon});
        tick();
        clearStrobes();
        expVal = expQ.pop_front(); nVec++;
        if ({31'd0, dp.CONFF} !== expVal) begin nErr++; $display("[TB] FAIL %s_conff got=%b exp=%h", tag, dp.CONFF, expVal); end
        dp.PCout = 1'b1; dp.Yin = 1'b1;
        tick();
        clearStrobes();
        dp.Csignout = 1'b1; dp.ADD = 1'b1; dp.Zlowin = 1'b1;
        expQ.push_back(32'd1);
        tick();
        clearStrobes(); dp.Zlowout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL %s_z got=%h exp=%h", tag, dp.BusMuxOut, expVal); end
        dp.PCin = dp.CONFF;
        expQ.push_back(32'd1);
        tick();
        clearStrobes(); dp.PCout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL %s_pc got=%h exp=%h", tag, dp.BusMuxOut, expVal); end
        clearStrobes();
    endtask

    task automatic test_brzr;
        branchSequence(1'b1, "brzr_taken");
        loadRa(32'd5);
        dp.Gra = 1'b1; dp.Rout = 1'b1; expQ.push_back(32'd5); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL brzr_r1 got=%h exp=%h", dp.BusMuxOut, expVal); end
        branchSequence(1'b0, "brzr_not_taken");
    endtask

    task automatic test_conditions;
        logic [31:0] vals [3];
        logic [1:0]  c2;
        vals[0] = 32'h00000000;
        vals[1] = 32'h00000007;
        vals[2] = 32'h80000000;
        for (int c = 0; c < 4; c++) begin
            c2 = 2'(c);
            loadIr((32'd1 << 23) | (32'(c) << 19));
            for (int k = 0; k < 3; k++) begin
                loadRa(vals[k]);
                dp.Gra = 1'b1; dp.Rout = 1'b1; dp.CONin = 1'b1;
                expQ.push_back({31'd0, condModel(c2, vals[k])});
                tick();
                clearStrobes();
                expVal = expQ.pop_front(); nVec++;
                if ({31'd0, dp.CONFF} !== expVal) begin
                    nErr++;
                    $display("[TB] FAIL cond_c2_%0d_bus_%h got=%b exp=%h", c, vals[k], dp.CONFF, expVal);
                end
            end
        end
    endtask

    task automatic test_alu_signext;
        loadIr(32'h0007FFFF);
        dp.Csignout = 1'b1; expQ.push_back(32'hFFFFFFFF); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL signext_c got=%h exp=%h", dp.BusMuxOut, expVal); end
        loadMdr(32'd5);
        dp.MDRout = 1'b1; dp.Yin = 1'b1;
        tick();
        clearStrobes();
        dp.Csignout = 1'b1; dp.ADD = 1'b1; dp.Zlowin = 1'b1; dp.Zhighin = 1'b1;
        expQ.push_back(32'd4);
        expQ.push_back(32'd0);
        tick();
        clearStrobes(); dp.Zlowout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL alu_add_zlow got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes(); dp.Zhighout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL alu_add_zhigh got=%h exp=%h", dp.BusMuxOut, expVal); end
        // No operation selected gives 0
        clearStrobes(); dp.Csignout = 1'b1; dp.Zlowin = 1'b1;
        expQ.push_back(32'd0);
        tick();
        clearStrobes(); dp.Zlowout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL alu_noop got=%h exp=%h", dp.BusMuxOut, expVal); end
        // IncPC beats ADD: MDR(5)+1, not Y+MDR
        clearStrobes(); dp.MDRout = 1'b1; dp.IncPC = 1'b1; dp.ADD = 1'b1; dp.Zlowin = 1'b1;
        expQ.push_back(32'd6);
        tick();
        clearStrobes(); dp.Zlowout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL alu_incpc_prio got=%h exp=%h", dp.BusMuxOut, expVal); end
        // ra=0 here: R0 holds data but BAout reads it as zero
        loadRa(32'h1234);
        dp.Gra = 1'b1; dp.Rout = 1'b1; expQ.push_back(32'h1234); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL r0_rout got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes(); dp.Gra = 1'b1; dp.BAout = 1'b1; expQ.push_back(32'd0); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL r0_baout got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes(); dp.Rout = 1'b1; expQ.push_back(32'd0); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL rout_nosel got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes();
    endtask

    task automatic test_priority_select;
        // State now: PC=1, MDR=0x1234, Z=6, C=-1, R0=0x1234
        dp.PCout = 1'b1; dp.MDRout = 1'b1; dp.Zlowout = 1'b1; expQ.push_back(32'd1); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL prio_pc got=%h exp=%h", dp.BusMuxOut, expVal); end
        dp.PCout = 1'b0; dp.Csignout = 1'b1; expQ.push_back(32'h1234); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL prio_mdr got=%h exp=%h", dp.BusMuxOut, expVal); end
        dp.MDRout = 1'b0; dp.Zhighout = 1'b1; expQ.push_back(32'd6); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL prio_zlow got=%h exp=%h", dp.BusMuxOut, expVal); end
        dp.Zlowout = 1'b0; expQ.push_back(32'd0); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL prio_zhigh got=%h exp=%h", dp.BusMuxOut, expVal); end
        dp.Zhighout = 1'b0; dp.Gra = 1'b1; dp.Rout = 1'b1; expQ.push_back(32'hFFFFFFFF); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL prio_csign got=%h exp=%h", dp.BusMuxOut, expVal); end
        // Rin without a register selection writes nothing
        loadMdr(32'h55);
        dp.MDRout = 1'b1; dp.Rin = 1'b1;
        tick();
        clearStrobes(); dp.Gra = 1'b1; dp.Rout = 1'b1; expQ.push_back(32'h1234); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL rin_nosel got=%h exp=%h", dp.BusMuxOut, expVal); end
        // ra=0, rb=3: Grb writes R3, Gra still wins when both are set
        loadIr(32'h00180000);
        loadMdr(32'h77);
        dp.MDRout = 1'b1; dp.Grb = 1'b1; dp.Rin = 1'b1;
        tick();
        clearStrobes(); dp.Grb = 1'b1; dp.Rout = 1'b1; expQ.push_back(32'h77); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL grb_r3 got=%h exp=%h", dp.BusMuxOut, expVal); end
        dp.Gra = 1'b1; expQ.push_back(32'h1234); #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL gra_over_grb got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes();
    endtask

    task automatic test_back_to_back;
        logic [31:0] pcModel;
        // Same-cycle read and load of MDR: old value on the bus, new after the edge
        dp.MDRout = 1'b1; dp.MDRin = 1'b1; dp.Read = 1'b1; dp.Mdatain = 32'hCAFEF00D;
        expQ.push_back(32'h77);
        expQ.push_back(32'hCAFEF00D);
        #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL mdr_old_value got=%h exp=%h", dp.BusMuxOut, expVal); end
        tick();
        dp.MDRin = 1'b0; dp.Read = 1'b0; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL mdr_new_value got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes();
        // Consecutive PC increments through Z, each address also going to MAR
        pcModel = 32'd1;
        for (int i = 0; i < 3; i++) begin
            dp.PCout = 1'b1; dp.MARin = 1'b1; dp.IncPC = 1'b1; dp.Zlowin = 1'b1;
            expQ.push_back(pcModel);
            pcModel = pcModel + 32'd1;
            expQ.push_back(pcModel);
            tick();
            clearStrobes();
            expVal = expQ.pop_front(); nVec++;
            if (dp.MAR_q !== expVal) begin nErr++; $display("[TB] FAIL b2b_mar_%0d got=%h exp=%h", i, dp.MAR_q, expVal); end
            dp.Zlowout = 1'b1; dp.PCin = 1'b1;
            tick();
            clearStrobes(); dp.PCout = 1'b1; #1;
            expVal = expQ.pop_front(); nVec++;
            if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL b2b_pc_%0d got=%h exp=%h", i, dp.BusMuxOut, expVal); end
            clearStrobes();
        end
        // Without Read/MD_read the MDR loads from the bus
        dp.PCout = 1'b1; dp.MDRin = 1'b1; dp.Mdatain = 32'hFFFF0000;
        expQ.push_back(pcModel);
        tick();
        clearStrobes(); dp.MDRout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL mdr_from_bus got=%h exp=%h", dp.BusMuxOut, expVal); end
        // MD_read alone also selects memory data
        clearStrobes(); dp.PCout = 1'b1; dp.MDRin = 1'b1; dp.MD_read = 1'b1; dp.Mdatain = 32'h0BADC0DE;
        expQ.push_back(32'h0BADC0DE);
        tick();
        clearStrobes(); dp.MDRout = 1'b1; #1;
        expVal = expQ.pop_front(); nVec++;
        if (dp.BusMuxOut !== expVal) begin nErr++; $display("[TB] FAIL mdr_md_read got=%h exp=%h", dp.BusMuxOut, expVal); end
        clearStrobes();
    endtask

    // Run every scenario in order, then report
    initial begin
        nVec  = 0;
        nErr  = 0;
        clear = 1'b0;
        clearStrobes();
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
        test_reset();
        test_fetch();
        test_brzr();
        test_conditions();
        test_alu_signext();
        test_priority_select();
        test_back_to_back();
        if (expQ.size() != 0) begin
            nErr++;
            $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
